// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and single-ported memory bus
// shared by mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ready;
  logic                  dm_read;
  logic                  dm_write;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ready;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (
    input  if_req, if_addr,
    input  dm_read, dm_write,
    input  dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output dm_rdata, dm_ready,
    output stall,
    output mem_req, mem_we,
    output mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr,
    output dm_read, dm_write,
    output dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  dm_rdata, dm_ready,
    input  stall,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and data
// ports; data has priority, bounded by a starvation counter.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {
    IDLE, BUSY_D, BUSY_I, RESP
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic [3:0]            starve_q, starve_d;
  logic                  owner_dm_q, owner_dm_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic dm_req;
  logic starved;
  logic if_ready;
  logic dm_ready;

  assign dm_req  = bus.dm_read | bus.dm_write;
  assign starved = bus.if_req && (starve_q == LIMIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      owner_dm_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_dm_q  <= owner_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    owner_dm_d  = owner_dm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req && !starved) begin
          state_d     = BUSY_D;
          owner_dm_d  = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_write;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          starve_d    = bus.if_req ? starve_q + 4'd1 : 4'd0;
        end else if (bus.if_req) begin
          state_d    = BUSY_I;
          owner_dm_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.if_addr;
          starve_d   = 4'd0;
        end else begin
          starve_d = 4'd0;
        end
      end
      BUSY_D, BUSY_I: begin
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          // mem_we_q still tells read from write here
          if (!mem_we_q) begin
            if (state_q == BUSY_D) dm_rdata_d = bus.mem_rdata;
            else                   if_rdata_d = bus.mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if_ready = 1'b0;
    dm_ready = 1'b0;
    if (state_q == RESP) begin
      if_ready = !owner_dm_q;
      dm_ready = owner_dm_q;
    end
  end

  assign bus.if_ready  = if_ready;
  assign bus.dm_ready  = dm_ready;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall     = (bus.if_req & ~if_ready)
                       | (dm_req & ~dm_ready);
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer sharing one single-ported memory between the instruction-fetch port and the data port (the port driven by the decoded readmem/writemem controls). It grants one requester at a time, drives a registered request/acknowledge transaction to memory, returns read data with a one-cycle ready pulse, and produces the pipeline stall. Data accesses have priority. A starvation counter forces an instruction grant after a bounded run of data grants.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending; range 1..15
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- if_req  in  1  instruction fetch request; held until if_ready
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req
- if_rdata  out  DATA_WIDTH  fetched word; valid when if_ready
- if_ready  out  1  one-cycle completion pulse for the fetch
- dm_read  in  1  data read request (readmem)
- dm_write  in  1  data write request (writemem)
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  write data
- dm_rdata  out  DATA_WIDTH  read data; valid when dm_ready after a read
- dm_ready  out  1  one-cycle completion pulse for the data access
- stall  out  1  pipeline stall
- mem_req  out  1  memory request; registered
- mem_we  out  1  memory write enable; registered
- mem_addr  out  ADDR_WIDTH  memory address; registered
- mem_wdata  out  DATA_WIDTH  memory write data; registered
- mem_rdata  in  DATA_WIDTH  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; may assert in the first cycle of mem_req

## Operation
- States: IDLE, BUSY_D, BUSY_I, RESP.
- IDLE, grant rule:
  - dm_req = dm_read|dm_write.
  - Grant data if dm_req, unless if_req is high and starve_cnt == STARVE_LIMIT. In that case grant instruction.
  - Otherwise grant instruction if if_req.
  - Otherwise stay in IDLE.
- On grant:
  - Register mem_addr, mem_wdata, mem_we and the owner.
  - mem_req is set to 1 and the block enters BUSY_D or BUSY_I.
  - mem_we = dm_write for a data grant. dm_read and dm_write both high is treated as a write.
  - mem_we = 0 and mem_wdata is unchanged for an instruction grant.
- BUSY_x:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant until mem_ack.
  - On mem_ack: mem_req and mem_we are cleared and the block enters RESP.
  - A read latches mem_rdata into dm_rdata or if_rdata, per owner.
  - A write leaves dm_rdata unchanged.
- RESP:
  - The owner's ready is high for exactly this cycle.
  - No grant is made in RESP, so the completing requester can drop or renew its request.
  - Next state is IDLE.
- starve_cnt (4 bits):
  - Increments on each data grant made while if_req is high.
  - Clears on an instruction grant, and whenever if_req is low in IDLE.
  - Saturates at STARVE_LIMIT.
- mem_ack outside BUSY_x is ignored.
- stall = (if_req & ~if_ready) | (dm_req & ~dm_ready). It is combinational.
- Reset values:
  - State IDLE; starve_cnt 0.
  - mem_req, mem_we, if_ready, dm_ready = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- Reset mid-transaction abandons the access: mem_req is low in the cycle after reset is sampled, and a late mem_ack is ignored.

## Timing
- Best-case latency, with mem_ack in the first mem_req cycle:
  - Cycle 0: request sampled in IDLE.
  - Cycle 1: mem_req high, mem_ack high.
  - Cycle 2: ready pulse with data.
  - Cycle 3: IDLE.
- Each added memory wait cycle adds exactly one cycle.
- Back-to-back: a request held through RESP is granted in the first IDLE cycle. Each access therefore occupies a minimum of 3 cycles.
- Simultaneous if_req and dm_req in IDLE: data wins unless starve_cnt == STARVE_LIMIT.
- A request raised during another owner's BUSY or RESP waits and is evaluated in the next IDLE.
- stall is high from the cycle the request is asserted through the cycle before its ready pulse. It is low in the ready cycle.

## Test plan
- Single fetch: if_addr=0x40, ack in first mem_req cycle, mem_rdata=0x2402000A.
  - Required: mem_req in cycle 1, mem_we=0, mem_addr=0x40.
  - Required: if_ready and if_rdata=0x2402000A in cycle 2; stall high in cycles 0-1.
- Data write with 3 wait cycles: dm_write, dm_addr=0x100, dm_wdata=0xDEADBEEF.
  - Required: mem_req/mem_we held 4 cycles with constant addr/data.
  - Required: dm_ready in the cycle after ack; dm_rdata unchanged.
- Simultaneous if_req and dm_read in IDLE: data is granted first; instruction is granted in the IDLE after the dm_ready pulse.
- Starvation, STARVE_LIMIT=4, if_req held and dm_read renewed continuously:
  - Required: 4 data grants, then 1 instruction grant, then the counter restarts.
- Reset asserted during BUSY_D, with mem_ack arriving 2 cycles later:
  - Required: mem_req=0 after the reset edge; no dm_ready; all outputs at reset values; state IDLE.
- Stray mem_ack=1 while IDLE with no requests: no state change; no ready pulse; mem_req stays 0.
